// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential four-digit BCD to 10-bit binary converter.
// Uses reverse double-dabble: 14 right shifts of {bcd, bin}, and after each
// shift every BCD digit >= 8 is reduced by 3.
// Optional feature macro: BCD_TO_BIN_ERR_CHECK_EN
//   defined   -> invalid digits (> 9) finish at once with err=1, and results
//                above 1023 report err=1 with bin_out=0.
//   undefined -> err is always 0 and the result is truncated to 10 bits.
module bcd_to_bin_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bcd_in,
  output logic        busy,
  output logic        done,
  output logic [9:0]  bin_out,
  output logic        err
);

  localparam int unsigned BCD_W  = 16;
  localparam int unsigned BIN_W  = 14;
  localparam int unsigned OUT_W  = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned N_DIG  = BCD_W / DIG_W;
  localparam int unsigned N_ITER = 14;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [BCD_W-1:0] bcd_q,     bcd_d;
  logic [BIN_W-1:0] bin_q,     bin_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [OUT_W-1:0] bin_out_q, bin_out_d;
  logic             err_q,     err_d;

  logic [BCD_W-1:0] bcd_sh;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] bin_sh;
  logic             last_iter;

  // Reduce one BCD digit by 3 when it is 8 or more (never underflows).
  function automatic logic [DIG_W-1:0] dig_adjust(input logic [DIG_W-1:0] d);
    logic [DIG_W-1:0] r;
    r = d;
    if (d >= DIG_W'(8)) begin
      r = d - DIG_W'(3);
    end
    return r;
  endfunction

  // One reverse double-dabble step on the current register contents.
  always_comb begin
    bcd_sh  = {1'b0, bcd_q[BCD_W-1:1]};
    bin_sh  = {bcd_q[0], bin_q[BIN_W-1:1]};
    bcd_adj = bcd_sh;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      bcd_adj[i*DIG_W +: DIG_W] = dig_adjust(bcd_sh[i*DIG_W +: DIG_W]);
    end
  end

  assign last_iter = (cnt_q == CNT_W'(N_ITER - 1));

`ifdef BCD_TO_BIN_ERR_CHECK_EN
  logic digit_bad;
  logic overflow;

  // Digit validity of the captured word and range check of the final result.
  always_comb begin
    digit_bad = 1'b0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (bcd_q[i*DIG_W +: DIG_W] > DIG_W'(9)) begin
        digit_bad = 1'b1;
      end
    end
    overflow = (bin_sh[BIN_W-1:OUT_W] != '0);
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bin_out_d = bin_out_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          bcd_d   = bcd_in;
          bin_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
`ifdef BCD_TO_BIN_ERR_CHECK_EN
        if ((cnt_q == '0) && digit_bad) begin
          // Malformed input: skip the conversion entirely.
          bin_out_d = '0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          bcd_d = bcd_adj;
          bin_d = bin_sh;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            bin_out_d = overflow ? '0 : bin_sh[OUT_W-1:0];
            err_d     = overflow;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end
        end
`else
        bcd_d = bcd_adj;
        bin_d = bin_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          bin_out_d = bin_sh[OUT_W-1:0];
          err_d     = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
`endif
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed testbench for bcd_to_bin_seq (expectations follow BCD_TO_BIN_ERR_CHECK_EN).
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  int errors = 0;
  int checks = 0;

  bcd_to_bin_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 16'h0000;
    #12;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++;
    if (bin_out !== 10'd0) begin errors++; $display("FAIL reset_bin got=%0d exp=0", bin_out); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Start one conversion; optionally re-pulse start with a different word at N+perturb.
  task automatic run_conv(input string name, input logic [15:0] bcd, input int exp_lat,
                          input logic chk_bin, input logic [9:0] exp_bin,
                          input logic exp_err, input int perturb);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    bcd_in = bcd;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_at_accept got=%0b exp=1", name, busy); end
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (perturb != 0 && k == perturb) begin start = 1'b1; bcd_in = 16'h0999; end
      if (perturb != 0 && k == perturb + 1) start = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1;
        lat = k;
      end else if (busy !== 1'b1) begin
        errors++; checks++;
        $display("FAIL %s busy_mid cycle=%0d got=%0b exp=1", name, k, busy);
      end
    end
    start = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL %s done_timeout got=none exp=done at N+%0d", name, exp_lat); end
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_in_done got=%0b exp=1", name, busy); end
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL %s err got=%0b exp=%0b", name, err, exp_err); end
    if (chk_bin) begin
      checks++;
      if (bin_out !== exp_bin) begin errors++; $display("FAIL %s bin_out got=%0d exp=%0d", name, bin_out, exp_bin); end
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got=%0b exp=0", name, done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got=%0b exp=0", name, busy); end
    if (chk_bin) begin
      checks++;
      if (bin_out !== exp_bin) begin errors++; $display("FAIL %s bin_hold got=%0d exp=%0d", name, bin_out, exp_bin); end
    end
  endtask

  task automatic test_max();
    run_conv("bcd1023", 16'h1023, 14, 1'b1, 10'h3FF, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_conv("bcd0000", 16'h0000, 14, 1'b1, 10'd0, 1'b0, 0);
    run_conv("bcd0999", 16'h0999, 14, 1'b1, 10'd999, 1'b0, 0);
  endtask

  task automatic test_overflow();
`ifdef BCD_TO_BIN_ERR_CHECK_EN
    run_conv("bcd1024", 16'h1024, 14, 1'b1, 10'd0, 1'b1, 0);
    run_conv("bcd9999", 16'h9999, 14, 1'b1, 10'd0, 1'b1, 0);
`else
    run_conv("bcd1024", 16'h1024, 14, 1'b1, 10'd0, 1'b0, 0);
    run_conv("bcd9999", 16'h9999, 14, 1'b1, 10'd783, 1'b0, 0);
`endif
  endtask

  task automatic test_bad_digit();
`ifdef BCD_TO_BIN_ERR_CHECK_EN
    run_conv("bcd00A5", 16'h00A5, 1, 1'b1, 10'd0, 1'b1, 0);
`else
    run_conv("bcd00A5", 16'h00A5, 14, 1'b0, 10'd0, 1'b0, 0);
`endif
  endtask

  task automatic test_ignore_start();
    run_conv("bcd0512", 16'h0512, 14, 1'b1, 10'd512, 1'b0, 5);
  endtask

  task automatic test_mid_reset();
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    bcd_in = 16'h0777;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    checks++;
    if (bin_out !== 10'd0) begin errors++; $display("FAIL midrst_bin got=%0d exp=0", bin_out); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%0b exp=0", err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL midrst_no_done got=activity exp=idle"); end
    run_conv("bcd0042", 16'h0042, 14, 1'b1, 10'd42, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_overflow();
    test_bad_digit();
    test_ignore_start();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, async active-low reset.
REQ-002 SHALL have port start, input, 1 bit: request pulse; accepted only in IDLE.
REQ-003 SHALL have port bcd_in, input, 16 bits: four packed BCD digits; [15:12] thousands, [3:0] units.
REQ-004 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-005 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-006 SHALL have port bin_out, output, 10 bits: binary result, held until the next accepted start.
REQ-007 SHALL have port err, output, 1 bit: error flag qualified by done, held with bin_out.

Function
REQ-008 SHALL implement reverse double-dabble with FSM states IDLE, SHIFT and DONE.
REQ-009 SHALL, with start=1 in IDLE at edge N, capture bcd_in into a 16-bit BCD register, clear a 14-bit binary shift register and a 4-bit counter, and enter SHIFT.
REQ-010 SHALL, in each SHIFT cycle, shift {bcd_reg, bin_reg} right by one; then, for each 4-bit digit of the shifted BCD part that is >= 8, subtract 3 from that digit.
REQ-011 SHALL perform exactly 14 iterations; the 14th occurs at edge N+14, and FSM enters DONE at that edge.
REQ-012 SHALL, on entering DONE, load bin_out with bin_reg[9:0] and err with the error result; done=1 for exactly the DONE cycle, then IDLE.
REQ-013 SHALL hold busy=1 from edge N through the DONE cycle inclusive; busy=0 only in IDLE.
REQ-014 SHALL ignore start in SHIFT and DONE; bcd_in is sampled only at acceptance and later changes have no effect.
REQ-015 SHALL allow back-to-back operation: start high in the cycle after DONE is accepted normally.
REQ-016 SHALL keep all arithmetic unsigned; digit subtraction never underflows because it applies only to digits >= 8.

Reset
REQ-017 SHALL, on rst_n=0 and independent of clk, force IDLE, busy=0, done=0, bin_out=10'd0, err=0, and clear all internal registers.
REQ-018 SHALL abort a conversion in progress when reset is asserted mid-operation, with no done pulse; the first start after release is processed normally.

Configuration
REQ-019 SHALL support macro BCD_TO_BIN_ERR_CHECK_EN.
REQ-020 SHALL, when BCD_TO_BIN_ERR_CHECK_EN is defined:
- At acceptance, any digit > 9 bypasses SHIFT and goes directly to DONE at edge N+1, with err=1 and bin_out=0.
- A valid input whose 14-bit result exceeds 1023 gives err=1 and bin_out=0 at edge N+14.
REQ-021 SHALL, when BCD_TO_BIN_ERR_CHECK_EN is undefined:
- err is constant 0.
- No digit check is done; every conversion takes 14 iterations.
- bin_out = bin_reg[9:0], truncated with no indication.

Verification
REQ-022 SHALL test bcd_in=16'h1023, start at edge N -> done at N+14, bin_out=10'h3FF, err=0, busy high N..N+14.
REQ-023 SHALL test bcd_in=16'h0000, then 16'h0999 back-to-back -> bin_out=0 then 10'd999; each done is one cycle.
REQ-024 SHALL test bcd_in=16'h1024 -> with EN: err=1, bin_out=0 at N+14; without EN: err=0, bin_out=10'd0 (1024 mod 1024).
REQ-025 SHALL test bcd_in=16'h00A5 -> with EN: done at N+1, err=1, bin_out=0; without EN: done at N+14, err=0.
REQ-026 SHALL test start re-pulsed and bcd_in changed at N+5 during 16'h0512 -> ignored; bin_out=10'd512 at N+14.
REQ-027 SHALL test rst_n low at N+7 of a 16'h0777 conversion -> immediate IDLE, all outputs 0, no done; a new start for 16'h0042 after release -> 10'd42.
